// File: rtl/updown_count_monitor_pkg.sv
// updown_mon_pkg: shared types for the up/down count monitor.
//   state_e : monitor FSM states (INIT, ACQ, LOCK)
//   step_e  : classification of one sample-to-sample step
//   RUN_W   : run-length counter width, wide enough for LOCK_CNT up to 15
package updown_mon_pkg;

    typedef enum logic [1:0] {
        INIT,
        ACQ,
        LOCK
    } state_e;

    typedef enum logic [1:0] {
        STEP_UP,
        STEP_DN,
        STEP_HOLD,
        STEP_BAD
    } step_e;

    localparam int RUN_W = 4;

endpackage

// File: rtl/updown_count_monitor_if.sv
// updown_count_monitor_if: observed count bus plus monitor status.
//   count_in : observed counter value (driven by the counter side)
//   locked, dir_up, dir_chg, wrap, step_err, err_cnt : monitor status
// Modports: master = counter/observer side, slave = monitor side.
interface updown_count_monitor_if #(
    parameter int WIDTH = 3,
    parameter int ERR_W = 8
);
    logic [WIDTH-1:0] count_in;
    logic             locked;
    logic             dir_up;
    logic             dir_chg;
    logic             wrap;
    logic             step_err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output count_in,
        input  locked, dir_up, dir_chg, wrap, step_err, err_cnt
    );

    modport slave (
        input  count_in,
        output locked, dir_up, dir_chg, wrap, step_err, err_cnt
    );
endinterface

// File: rtl/updown_step_classify.sv
// updown_step_classify: combinational step classifier.
//   prev      : previous sample
//   cur       : current sample
//   cls       : STEP_UP (+1), STEP_DN (-1), STEP_HOLD (0), STEP_BAD (other),
//               all modulo 2^WIDTH
//   wrap_edge : step crosses max<->0 in either direction
module updown_step_classify
    import updown_mon_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] cur,
    output step_e            cls,
    output logic             wrap_edge
);
    logic [WIDTH-1:0] delta;

    assign delta = cur - prev;

    always_comb begin
        cls = STEP_BAD;
        if (delta == WIDTH'(1)) begin
            cls = STEP_UP;
        end else if (delta == '1) begin
            cls = STEP_DN;
        end else if (delta == '0) begin
            cls = STEP_HOLD;
        end
    end

    assign wrap_edge = ((prev == '1) && (cur == '0)) ||
                       ((prev == '0) && (cur == '1));
endmodule

// File: rtl/updown_count_monitor.sv
// updown_count_monitor: watches a counter's count bus, infers and locks the
// counting direction, and flags direction changes, wrap-around and illegal
// steps. All outputs are registered.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   mon  : slave modport; count_in in, status (locked, dir_up, dir_chg,
//          wrap, step_err, err_cnt) out
// Build option: define UPDOWN_MON_HOLD_ERR_EN to treat a stalled count
// while locked as an illegal step; otherwise stalls are ignored.
module updown_count_monitor
    import updown_mon_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    updown_count_monitor_if.slave mon
);
`ifdef UPDOWN_MON_HOLD_ERR_EN
    localparam bit HOLD_IS_ERR = 1'b1;
`else
    localparam bit HOLD_IS_ERR = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               run_dir_q, run_dir_d;
    logic               locked_q, locked_d;
    logic               dir_up_q, dir_up_d;
    logic               dir_chg_q, dir_chg_d;
    logic               wrap_q, wrap_d;
    logic               step_err_q, step_err_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

    step_e              cls;
    logic               wrap_edge;
    logic               is_move;
    logic               move_up;
    logic               lock_bad;
    logic [RUN_W-1:0]   run_nxt;

    updown_step_classify #(.WIDTH(WIDTH)) u_classify (
        .prev      (prev_q),
        .cur       (mon.count_in),
        .cls       (cls),
        .wrap_edge (wrap_edge)
    );

    assign is_move  = (cls == STEP_UP) || (cls == STEP_DN);
    assign move_up  = (cls == STEP_UP);
    // A stall only counts as an error once locked, and only when enabled.
    assign lock_bad = (cls == STEP_BAD) || (HOLD_IS_ERR && (cls == STEP_HOLD));
    // Continue the run if the direction matches, else restart at 1.
    assign run_nxt  = (move_up == run_dir_q) ? run_q + RUN_W'(1) : RUN_W'(1);

    always_comb begin
        state_d    = state_q;
        prev_d     = mon.count_in;
        run_d      = run_q;
        run_dir_d  = run_dir_q;
        locked_d   = locked_q;
        dir_up_d   = dir_up_q;
        dir_chg_d  = 1'b0;
        wrap_d     = 1'b0;
        step_err_d = 1'b0;

        unique case (state_q)
            INIT: begin
                // First sample after reset only seeds prev.
                state_d = ACQ;
                run_d   = '0;
            end
            ACQ: begin
                if (is_move) begin
                    run_d     = run_nxt;
                    run_dir_d = move_up;
                    if (run_nxt >= RUN_W'(LOCK_CNT)) begin
                        state_d  = LOCK;
                        locked_d = 1'b1;
                        dir_up_d = move_up;
                    end
                end else if (cls == STEP_BAD) begin
                    step_err_d = 1'b1;
                    run_d      = '0;
                end
            end
            LOCK: begin
                if (lock_bad) begin
                    step_err_d = 1'b1;
                    locked_d   = 1'b0;
                    state_d    = ACQ;
                    run_d      = '0;
                end else if (is_move) begin
                    if (move_up == dir_up_q) begin
                        wrap_d = wrap_edge;
                    end else begin
                        dir_chg_d = 1'b1;
                        run_d     = RUN_W'(1);
                        run_dir_d = move_up;
                        if (LOCK_CNT <= 1) begin
                            dir_up_d = move_up;
                        end else begin
                            locked_d = 1'b0;
                            state_d  = ACQ;
                        end
                    end
                end
            end
            default: state_d = INIT;
        endcase

        err_cnt_d = err_cnt_q;
        if (step_err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT;
            prev_q     <= '0;
            run_q      <= '0;
            run_dir_q  <= 1'b0;
            locked_q   <= 1'b0;
            dir_up_q   <= 1'b0;
            dir_chg_q  <= 1'b0;
            wrap_q     <= 1'b0;
            step_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            run_q      <= run_d;
            run_dir_q  <= run_dir_d;
            locked_q   <= locked_d;
            dir_up_q   <= dir_up_d;
            dir_chg_q  <= dir_chg_d;
            wrap_q     <= wrap_d;
            step_err_q <= step_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign mon.locked   = locked_q;
    assign mon.dir_up   = dir_up_q;
    assign mon.dir_chg  = dir_chg_q;
    assign mon.wrap     = wrap_q;
    assign mon.step_err = step_err_q;
    assign mon.err_cnt  = err_cnt_q;
endmodule

// File: doc/updown_count_monitor.md
Name: updown_count_monitor

Overview:
- Consumer-side companion to the up/down counter: observes a counter's count bus each clock and infers the direction of counting.
- Locks onto a direction after consistent steps; flags direction changes, wrap-around and illegal jumps, and keeps a saturating error count.
- Sits beside any counter instance as an in-circuit checker; feeds status/debug logic.

Parameters:
- WIDTH, 3, width of the observed count bus.
- LOCK_CNT, 2, consecutive same-direction steps needed to lock (legal range 1..15).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- count_in  input  WIDTH  observed counter value, sampled on every rising edge.
- locked  output  1  1 when the direction is locked.
- dir_up  output  1  locked direction: 1 = up, 0 = down; holds last locked value when unlocked.
- dir_chg  output  1  one-cycle pulse: opposite step seen while locked.
- wrap  output  1  one-cycle pulse: locked up and max->0 seen, or locked down and 0->max seen.
- step_err  output  1  one-cycle pulse: illegal step seen.
- err_cnt  output  ERR_W  saturating count of step_err pulses.

Behaviour:
- Reset (async assert, clock-synchronous use after release): state=INIT, prev=0, run=0, all outputs 0.
- Each edge: delta = (count_in - prev) mod 2^WIDTH. Classification:
  - delta 1 -> UP.
  - delta 2^WIDTH-1 -> DN.
  - delta 0 -> HOLD.
  - else -> BAD.
- prev <= count_in on every edge, in every state.
- All outputs are registered. A step between the samples at edges k-1 and k is reflected on the outputs after edge k.
- INIT: no comparison is made; go to ACQ with run=0. The first sample after reset never produces an error.
- ACQ:
  - UP/DN in the same direction as run_dir: run+1. Otherwise run=1 and run_dir=new direction.
  - When run reaches LOCK_CNT: go to LOCK, locked=1, dir_up=run_dir.
  - HOLD: no change.
  - BAD: step_err, run=0.
- LOCK:
  - Same-direction step: stay in LOCK. Pulse wrap on the edge whose step crosses max<->0.
  - Opposite step: dir_chg pulse, locked=0, go to ACQ with run=1 in the new direction. With LOCK_CNT=1, go to LOCK directly with the new dir_up and still pulse dir_chg.
  - BAD: step_err, locked=0, go to ACQ with run=0.
  - HOLD: see Optional Feature.
- err_cnt increments on each step_err and stops at 2^ERR_W-1.
- wrap, dir_chg and step_err are mutually exclusive in any cycle.
- Reset asserted mid-operation clears everything immediately. No pulse is emitted across reset.

Optional Feature:
- Macro: UPDOWN_MON_HOLD_ERR_EN.
- Defined: HOLD in LOCK is treated as BAD (step_err, err_cnt+1, unlock). The monitored counter must step every cycle.
- Undefined: HOLD is ignored in every state; the counter may stall.
- HOLD in ACQ is ignored in both builds.

Decomposition:
- Package updown_mon_pkg contains:
  - state enum {INIT, ACQ, LOCK}.
  - step-class enum {STEP_UP, STEP_DN, STEP_HOLD, STEP_BAD}.
  - a run-counter width constant sized for LOCK_CNT up to 15.
- Sub-module updown_step_classify: purely combinational; takes prev and count_in, returns the step class and a wrap-edge flag.
- Top level holds the state machine, the prev register and the counters.

Test Plan (WIDTH=3, LOCK_CNT=2, ERR_W=8):
- Reset: rst=1 at t=10 for 10 time units -> locked=0, dir_up=0, err_cnt=0, no pulses. The first sample after release produces no step_err.
- Up sequence 0,1,2,...,7,0,1 -> locked=1 and dir_up=1 after the edge sampling 2. wrap pulses exactly once, after the edge sampling 0 following 7. err_cnt stays 0.
- Locked up at 5, then 4,3,2,1,0,7 -> dir_chg pulse after 4; locked=1 with dir_up=0 after 3; wrap pulse after 7.
- Illegal jump 2->6 while locked -> step_err pulse, err_cnt 0->1, locked=0. Re-lock after two legal steps. Forcing 300 jumps -> err_cnt holds at 255.
- Hold 3,3,3 while locked up:
  - Macro undefined -> locked stays 1, no pulses.
  - Macro defined -> step_err after the first repeated 3, locked=0, err_cnt+1; the next 3 adds no error.
- rst pulsed asynchronously between edges while locked -> locked, dir_up, err_cnt go to 0 before the next edge. Resuming at count 6 gives no error and re-locks two steps later.
